// File: rtl/rst_seq.sv
// rst_seq: reset sequencer in front of the dual-clock FIFO reset controller.
// Latency: soft_rst_req -> rst_out high is two edges. Outputs are a registered image of the FSM state.
// Backpressure: none. Requests that arrive outside IDLE are dropped, not queued.
//
// Ports:
//   clk           sequencer clock
//   rst_n         asynchronous active-low reset; its deassertion is synchronized internally
//   soft_rst_req  single-cycle software reset request; only honoured in IDLE
//   dn_busy       asynchronous busy from the downstream controller (OR of its two domain resets)
//   rst_out       active-high reset to the downstream controller
//   busy          high while a sequence is in progress
//   done          one-cycle pulse when a sequence completes
//   ack_err       sticky; downstream handshake timed out (cleared only by rst_n)
//   rst_count     completed sequences, saturating at all-ones
module rst_seq #(
  parameter int MIN_CYCLES     = 16,
  parameter int HOLDOFF_CYCLES = 8,
  parameter int ACK_TIMEOUT    = 1024,
  parameter int SYNC_STAGES    = 3,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             soft_rst_req,
  input  logic             dn_busy,
  output logic             rst_out,
  output logic             busy,
  output logic             done,
  output logic             ack_err,
  output logic [CNT_W-1:0] rst_count
);

  // The shared counter must reach the largest terminal value of any state.
  localparam int MAX_A = (ACK_TIMEOUT > MIN_CYCLES) ? ACK_TIMEOUT : MIN_CYCLES;
  localparam int MAX_C = (MAX_A > HOLDOFF_CYCLES) ? MAX_A : HOLDOFF_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] MIN_LAST  = CW'(MIN_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF_CYCLES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_HOLDOFF = 2'd3;

  // ------------------------------------------------------------------
  // Synchronizers
  // ------------------------------------------------------------------
  // rst_n assertion is asynchronous; deassertion ripples through a flop chain
  // so the FSM leaves its held state on a clean edge.
  logic [SYNC_STAGES-1:0] rst_sync_q;
  // dn_busy chain resets to ones: after reset we assume the downstream is
  // still in reset until proven otherwise.
  logic [SYNC_STAGES-1:0] dn_sync_q;
  logic                   run;
  logic                   dn_busy_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
      dn_sync_q  <= '1;
    end else begin
      rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
      dn_sync_q  <= {dn_sync_q[SYNC_STAGES-2:0], dn_busy};
    end
  end

  assign run       = rst_sync_q[SYNC_STAGES-1];
  assign dn_busy_s = dn_sync_q[SYNC_STAGES-1];

  // ------------------------------------------------------------------
  // Sequencer FSM
  // ------------------------------------------------------------------
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ack_seen_q, ack_seen_d;
  logic          ack_err_q, ack_err_d;
  logic          enter_idle_q, enter_idle_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ack_seen_d   = ack_seen_q;
    ack_err_d    = ack_err_q;
    enter_idle_d = 1'b0;

    // Until the reset-release chain is full the FSM is frozen in ASSERT.
    if (run) begin
      cnt_d = cnt_q + CNT_ONE;
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (soft_rst_req) begin
            state_d    = ST_ASSERT;
            ack_seen_d = 1'b0;
          end
        end

        ST_ASSERT: begin
          if (dn_busy_s) begin
            ack_seen_d = 1'b1;
          end
          // Normal exit needs both the minimum width and evidence that the
          // downstream actually entered reset. The ack check has priority so
          // a late-but-present ack is never flagged as an error.
          if ((cnt_q >= MIN_LAST) && (ack_seen_q || dn_busy_s)) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
          end else if (cnt_q >= TO_LAST) begin
            state_d   = ST_RELEASE;
            cnt_d     = '0;
            ack_err_d = 1'b1;
          end
        end

        ST_RELEASE: begin
          if (!dn_busy_s) begin
            state_d = ST_HOLDOFF;
            cnt_d   = '0;
          end else if (cnt_q >= TO_LAST) begin
            state_d   = ST_HOLDOFF;
            cnt_d     = '0;
            ack_err_d = 1'b1;
          end
        end

        ST_HOLDOFF: begin
          // A request arriving on this exit edge is not looked at: only
          // requests sampled while already in IDLE start a sequence.
          if (cnt_q >= HOLD_LAST) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            enter_idle_d = 1'b1;
          end
        end

        default: begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ASSERT;
      cnt_q        <= '0;
      ack_seen_q   <= 1'b0;
      ack_err_q    <= 1'b0;
      enter_idle_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ack_seen_q   <= ack_seen_d;
      ack_err_q    <= ack_err_d;
      enter_idle_q <= enter_idle_d;
    end
  end

  // ------------------------------------------------------------------
  // Registered outputs
  // ------------------------------------------------------------------
  // Each output is decoded from the current state and registered, so all of
  // them move together one edge after the state does. done and the count
  // update share that edge with busy falling.
  logic             rst_out_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] rst_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_out_q   <= 1'b1;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      rst_count_q <= '0;
    end else begin
      rst_out_q <= (state_q == ST_ASSERT);
      busy_q    <= (state_q != ST_IDLE);
      done_q    <= enter_idle_q;
      if (enter_idle_q && (rst_count_q != {CNT_W{1'b1}})) begin
        rst_count_q <= rst_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign rst_out   = rst_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ack_err   = ack_err_q;
  assign rst_count = rst_count_q;

endmodule

// File: tb/tb_rst_seq.sv
module tb_rst_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       soft_rst_req;
  logic       dn_busy;
  logic       rst_out, busy, done, ack_err;
  logic [7:0] rst_count;
  logic       rst_out2, busy2, done2, ack_err2;
  logic [1:0] rst_count2;

  always #5 clk = ~clk;

  rst_seq u_dut (
    .clk(clk), .rst_n(rst_n), .soft_rst_req(soft_rst_req), .dn_busy(dn_busy),
    .rst_out(rst_out), .busy(busy), .done(done), .ack_err(ack_err), .rst_count(rst_count)
  );

  // Narrow-count twin sharing every input; used for saturation.
  rst_seq #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .soft_rst_req(soft_rst_req), .dn_busy(dn_busy),
    .rst_out(rst_out2), .busy(busy2), .done(done2), .ack_err(ack_err2), .rst_count(rst_count2)
  );

  // Downstream model: 0 = mirrors rst_out delayed 6 cycles, 1 = tied 0, 2 = stuck 1
  int         mode = 0;
  logic [5:0] dly  = '0;
  always @(posedge clk) dly <= {dly[4:0], rst_out};
  assign dn_busy = (mode == 0) ? dly[5] : (mode == 2);

  typedef struct {
    int cnt;
    int cnt2;
    int err;
    int wmin;
    int wmax;
    int rel;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int done_seen = 0;
  int high_run  = 0;
  int last_w    = 0;
  int rel_run   = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic push(input int c, input int c2, input int e, input int lo, input int hi, input int r);
    exp_t x;
    x.cnt = c; x.cnt2 = c2; x.err = e; x.wmin = lo; x.wmax = hi; x.rel = r;
    sb.push_back(x);
  endtask

  // Monitor: measures rst_out width and release-to-idle time, checks on each done.
  always @(negedge clk) begin
    exp_t e;
    if (rst_out) begin
      high_run++;
    end else if (high_run != 0) begin
      last_w   = high_run;
      high_run = 0;
      rel_run  = 0;
    end
    if (!rst_out && busy) rel_run++;

    if (done) begin
      done_seen++;
      chk("done_one_cycle", int'(prev_done), 0);
      chk("done_twin", int'(done2), 1);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=done required=none count=%0d", rst_count);
      end else begin
        e = sb.pop_front();
        chk("rst_count", int'(rst_count), e.cnt);
        chk("rst_count_sat", int'(rst_count2), e.cnt2);
        chk("ack_err", int'(ack_err), e.err);
        chk_rng("rst_width", last_w, e.wmin, e.wmax);
        chk("release_to_idle", rel_run, e.rel);
      end
    end
    prev_done = done;
  end

  task automatic wait_done(input int budget);
    int start;
    int n;
    start = done_seen;
    n = 0;
    while (done_seen == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", int'(done_seen != start), 1);
  endtask

  task automatic wait_lvl(input logic want, input int budget);
    int n;
    n = 0;
    while (rst_out != want && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("rst_out_level_reached", int'(rst_out), int'(want));
  endtask

  task automatic pulse_req();
    soft_rst_req = 1'b1;
    @(negedge clk);
    soft_rst_req = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    soft_rst_req = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("por_rst_out", int'(rst_out), 1);
    chk("por_busy", int'(busy), 1);
    chk("por_done", int'(done), 0);
    chk("por_ack_err", int'(ack_err), 0);
    chk("por_rst_count", int'(rst_count), 0);

    // Power-on sequence
    push(1, 1, 0, 19, 40, 19);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    wait_done(200);
    repeat (5) @(negedge clk);

    // Soft request latency and exact width
    push(2, 2, 0, 16, 16, 19);
    soft_rst_req = 1'b1;
    @(negedge clk);
    soft_rst_req = 1'b0;
    chk("lat_rst_out_edge1", int'(rst_out), 0);
    chk("lat_busy_edge1", int'(busy), 0);
    @(negedge clk);
    chk("lat_rst_out_edge2", int'(rst_out), 1);
    chk("lat_busy_edge2", int'(busy), 1);
    wait_done(200);
    repeat (5) @(negedge clk);

    // No ack at all: ASSERT timeout
    mode = 1;
    repeat (2) @(negedge clk);
    push(3, 3, 1, 1024, 1024, 9);
    pulse_req();
    wait_done(1200);
    mode = 0;
    repeat (10) @(negedge clk);

    // Ack never released: RELEASE timeout
    mode = 2;
    repeat (2) @(negedge clk);
    push(4, 3, 1, 16, 16, 1032);
    pulse_req();
    wait_done(1300);
    mode = 0;
    repeat (15) @(negedge clk);

    // Requests during ASSERT, RELEASE and HOLDOFF are dropped
    push(5, 3, 1, 16, 16, 19);
    pulse_req();
    wait_lvl(1'b1, 10);
    repeat (5) @(negedge clk);
    pulse_req();
    wait_lvl(1'b0, 40);
    pulse_req();
    repeat (10) @(negedge clk);
    pulse_req();
    wait_done(200);
    repeat (40) @(negedge clk);
    chk("no_extra_rst_out", int'(rst_out), 0);
    chk("no_extra_busy", int'(busy), 0);
    chk("no_extra_count", int'(rst_count), 5);

    // rst_n during HOLDOFF
    pulse_req();
    wait_lvl(1'b1, 10);
    wait_lvl(1'b0, 40);
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", int'(rst_out), 1);
    chk("mid_busy", int'(busy), 1);
    chk("mid_rst_count", int'(rst_count), 0);
    chk("mid_rst_count_sat", int'(rst_count2), 0);
    chk("mid_ack_err", int'(ack_err), 0);
    push(1, 1, 0, 19, 40, 19);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_done(200);
    repeat (10) @(negedge clk);

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
